conv3x3_engine: RTL and testbench
=================================

// Module: conv3x3_engine
// PURPOSE
// - Consumer/initiator side of the 3x3 kernel-coefficient read interface. Accepts one 3x3 pixel window,
//   reads taps 0..8 from a coefficient source with 1-cycle read latency, and multiply-accumulates each tap.
// - Returns the signed sum and a 0..255-clamped pixel. Sits between the line-buffer window generator and
//   the feature/threshold stage of the image pipeline.
// PARAMETERS
// - PIX_W   8   unsigned pixel width
// - COEF_W  9   signed coefficient width; matches the coefficient source data port
// - ADDR_W  4   coefficient address width
// - ACC_W   22  accumulator width; = PIX_W+1+COEF_W+4, which cannot overflow for 9 taps
// PORTS
// - clk         in   1          clock; all state changes on rising edge
// - reset       in   1          synchronous, active-high
// - win_valid   in   1          window present on win_pix
// - win_ready   out  1          engine can accept a window; high only in IDLE
// - win_pix     in   9*PIX_W    tap k at [k*PIX_W +: PIX_W]; row-major; k=4 is centre
// - coef_en     out  1          coefficient read strobe
// - coef_addr   out  ADDR_W     tap index being read, 0..8
// - coef_data   in   COEF_W     signed coefficient; valid the cycle after coef_en
// - res_valid   out  1          result available
// - res_ready   in   1          downstream takes result
// - res_data    out  ACC_W      signed sum of pix[k]*coef[k]
// - res_pix     out  PIX_W      res_data clamped to [0, 2^PIX_W-1]
// BEHAVIOUR
// - Reset: win_ready=0 during reset, then 1 the cycle after; coef_en=0, coef_addr=0, res_valid=0,
//   res_data=0, res_pix=0. Accumulator, tap counter and pipeline valid are cleared; state goes to IDLE.
// - States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
// - IDLE: win_ready=1. On win_valid&win_ready (cycle 0), latch all 9 pixels, clear the accumulator,
//   set idx=0, go to FETCH. win_pix is ignored outside acceptance.
// - FETCH: cycles 1..9. coef_en=1, coef_addr=idx, idx++. After idx==8 is issued, go to DRAIN.
// - MAC pipeline: a registered copy of (coef_en, coef_addr) qualifies each MAC. In cycles 2..10,
//   acc += $signed({1'b0,pix[idx_d]}) * $signed(coef_data).
// - Outside qualified cycles coef_data is don't-care and must not affect acc.
// - DRAIN: cycle 10; the last MAC lands; coef_en=0. Go to DONE.
// - DONE: from cycle 11, res_valid=1 and res_data/res_pix are stable; hold until res_ready.
//   On res_valid&res_ready, go to IDLE; res_valid=0 and win_ready=1 next cycle.
// - Latency: accept -> res_valid = 11 cycles. Minimum window-to-window spacing is 12 cycles with res_ready tied high.
// - Clamp: res_pix=0 if acc<0; 255 if acc>255; otherwise acc[PIX_W-1:0]. Registered with res_data.
// - Backpressure: while res_valid&!res_ready, all outputs hold, win_ready=0 and coef_en=0.
// - Reset mid-operation: abort immediately to the reset state. No partial result is emitted and
//   there is no stray coef_en after reset.
// - Simultaneous events: reset dominates all inputs. win_valid in a non-IDLE state is ignored; the
//   upstream holds it until win_ready.
// STRUCTURE
// - Shared package conv_pkg: TAPS=9, CENTRE_TAP=4, PIX_W, COEF_W, ACC_W, and state localparams
//   S_IDLE, S_FETCH, S_DRAIN, S_DONE (2-bit).
// - Sub-module conv_mac: registered signed multiply-accumulate (clr, en, pix, coef -> acc).
// - Top level keeps the FSM, the tap counter, the window register and the clamp.
// TESTING (pair with a 1-cycle-latency Laplacian coefficient model: 0,-1,0,-1,4,-1,0,-1,0)
// - Flat window, all pixels 100 -> res_data=0, res_pix=0, res_valid at accept+11.
// - Centre 200, others 0 -> res_data=800, res_pix=255 (clamp high).
// - Centre 0, taps 1/3/5/7=50 -> res_data=-200, res_pix=0 (clamp low, sign kept).
// - Centre 70, taps 1/3/5/7=60 -> res_data=40, res_pix=40.
// - Address trace -> coef_addr 0..8 in cycles 1..9 with coef_en high exactly 9 cycles; never >8.
// - Backpressure: res_ready low 5 cycles -> res_valid/res_data stable, win_ready=0; window accepted 1 cycle after handshake.
// - Reset asserted at cycle 5 of FETCH -> next cycle coef_en=0, res_valid=0; next window gives a correct result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and clamp helper for the 3x3 convolution engine.
package conv_pkg;
    localparam int TAPS       = 9;
    localparam int CENTRE_TAP = 4;
    localparam int PIX_W      = 8;
    localparam int COEF_W     = 9;
    localparam int ADDR_W     = 4;
    localparam int ACC_W      = 22;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Negative sums clamp to 0; anything with bits above the pixel range clamps to full scale.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic [ACC_W-1:0] v);
        if (v[ACC_W-1])
            return '0;
        else if (|v[ACC_W-2:PIX_W])
            return '1;
        else
            return v[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate; sum is the value the accumulator takes at the next edge.
module conv_mac
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix,
    input  logic [COEF_W-1:0] coef,
    output logic [ACC_W-1:0]  sum
);
    localparam int PROD_W = PIX_W + COEF_W + 1;

    logic signed [PIX_W:0]    pix_s;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         acc;

    // Pixels are unsigned, so a zero MSB makes them safe signed operands.
    assign pix_s  = {1'b0, pix};
    assign coef_s = coef;
    assign prod   = PROD_W'(pix_s) * PROD_W'(coef_s);
    assign sum    = en ? acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} : acc;

    always_ff @(posedge clk) begin
        if (reset || clr)
            acc <= '0;
        else
            acc <= sum;
    end
endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 window MAC engine: latches a window, fetches 9 coefficients (1-cycle read latency),
// accumulates pix*coef per tap and returns the signed sum plus a clamped pixel.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [TAPS*PIX_W-1:0] win_pix,
    output logic                  coef_en,
    output logic [ADDR_W-1:0]     coef_addr,
    input  logic [COEF_W-1:0]     coef_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res_data,
    output logic [PIX_W-1:0]      res_pix,
    output logic [1:0]            fsm_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid/data hold until that edge, and ready never depends combinationally on valid.
    state_t            state;
    logic [PIX_W-1:0]  pix_q [TAPS];
    logic              en_d;
    logic [ADDR_W-1:0] addr_d;
    logic              accept;
    logic [ACC_W-1:0]  sum;

    assign accept    = (state == S_IDLE) && win_valid && win_ready;
    assign fsm_state = state;

    // The delayed strobe/address line up with coef_data returning one cycle after the read.
    conv_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (en_d),
        .pix   (pix_q[addr_d]),
        .coef  (coef_data),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            win_ready <= 1'b0;
            coef_en   <= 1'b0;
            coef_addr <= '0;
            en_d      <= 1'b0;
            addr_d    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_pix   <= '0;
        end else begin
            en_d   <= coef_en;
            addr_d <= coef_addr;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < TAPS; k++)
                            pix_q[k] <= win_pix[k*PIX_W +: PIX_W];
                        win_ready <= 1'b0;
                        coef_en   <= 1'b1;
                        coef_addr <= '0;
                        state     <= S_FETCH;
                    end else begin
                        win_ready <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (coef_addr == LAST_TAP) begin
                        coef_en   <= 1'b0;
                        coef_addr <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        coef_addr <= coef_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Capture the sum including the final tap as it lands.
                    res_valid <= 1'b1;
                    res_data  <= sum;
                    res_pix   <= clamp_pix(sum);
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        win_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine with a Laplacian coefficient source and a per-cycle timing/result model.
module tb_conv3x3_engine;
    logic        clk;
    logic        reset;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_pix;
    logic        coef_en;
    logic [3:0]  coef_addr;
    logic [8:0]  coef_data;
    logic        res_valid;
    logic        res_ready;
    logic [21:0] res_data;
    logic [7:0]  res_pix;
    logic [1:0]  fsm_state;

    conv3x3_engine dut (
        .clk       (clk),
        .reset     (reset),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_pix   (win_pix),
        .coef_en   (coef_en),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_pix   (res_pix),
        .fsm_state (fsm_state)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic rst_sampled = 1'b1;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_sampled <= reset;
    end

    // Laplacian coefficient source, 1-cycle read latency; junk when not read
    int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};

    always @(posedge clk) begin
        if (coef_en && coef_addr < 4'd9)
            coef_data <= 9'(lap[coef_addr]);
        else
            coef_data <= 9'($urandom_range(0, 511));
    end

    task automatic check(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    // behavioural model
    function automatic int model_sum(input logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++)
            s += int'(w[k*8 +: 8]) * lap[k];
        return s;
    endfunction

    function automatic int model_clamp(input int s);
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endfunction

    function automatic logic [71:0] pack9(input int c, input int n, input int w,
                                          input int e, input int s, input int corner);
        logic [71:0] v;
        v = '0;
        v[0*8 +: 8] = 8'(corner);
        v[1*8 +: 8] = 8'(n);
        v[2*8 +: 8] = 8'(corner);
        v[3*8 +: 8] = 8'(w);
        v[4*8 +: 8] = 8'(c);
        v[5*8 +: 8] = 8'(e);
        v[6*8 +: 8] = 8'(corner);
        v[7*8 +: 8] = 8'(s);
        v[8*8 +: 8] = 8'(corner);
        return v;
    endfunction

    // scoreboard
    logic [21:0] exp_q[$];
    logic [7:0]  exp_pix_q[$];
    bit          active = 1'b0;
    int          acc_cyc = 0;
    int          hs_cyc = 0;
    int          last_data = 0;
    int          last_pix = 0;
    int          d;
    bit          exp_en;
    bit          exp_rv;

    always @(negedge clk) begin
        if (rst_sampled) begin
            check("rst_win_ready", win_ready, 0);
            check("rst_coef_en", coef_en, 0);
            check("rst_coef_addr", coef_addr, 0);
            check("rst_res_valid", res_valid, 0);
            check("rst_res_data", res_data, 0);
            check("rst_res_pix", res_pix, 0);
            check("rst_state", fsm_state, 0);
            active = 1'b0;
            exp_q.delete();
            exp_pix_q.delete();
        end else begin
            d      = cyc - acc_cyc;
            exp_en = active && d >= 1 && d <= 9;
            exp_rv = active && d >= 11;
            check("coef_en", coef_en, exp_en);
            if (exp_en)
                check("coef_addr", coef_addr, d - 1);
            check("res_valid", res_valid, exp_rv);
            check("win_ready", win_ready, !active);
            if (exp_rv && res_valid && exp_q.size() > 0) begin
                check("res_data", int'($signed(res_data)), int'($signed(exp_q[0])));
                check("res_pix", res_pix, exp_pix_q[0]);
                check("done_state", fsm_state, 3);
            end
            if (win_valid && win_ready && !reset) begin
                int s;
                s = model_sum(win_pix);
                exp_q.push_back(22'(s));
                exp_pix_q.push_back(8'(model_clamp(s)));
                active  = 1'b1;
                acc_cyc = cyc;
            end else if (res_valid && res_ready && exp_rv) begin
                last_data = int'($signed(res_data));
                last_pix  = res_pix;
                hs_cyc    = cyc;
                active    = 1'b0;
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_pix_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic wait_accept();
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (win_ready) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 win_valid = 1'b0;
    endtask

    task automatic send_window(input logic [71:0] w);
        win_pix   = w;
        win_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_handshake();
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("result_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string name, input logic [71:0] w,
                            input int exp_data, input int exp_pix);
        send_window(w);
        win_pix = $urandom();
        wait_handshake();
        check({name, "_data"}, last_data, exp_data);
        check({name, "_pix"}, last_pix, exp_pix);
    endtask

    initial begin : main
        int prev_acc;
        bit hit;
        reset     = 1'b1;
        win_valid = 1'b0;
        win_pix   = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_case("flat", pack9(100, 100, 100, 100, 100, 100), 0, 0);
        prev_acc = acc_cyc;
        run_case("centre200", pack9(200, 0, 0, 0, 0, 0), 800, 255);
        check("spacing", acc_cyc - prev_acc, 12);
        run_case("neg", pack9(0, 50, 50, 50, 50, 0), -200, 0);
        run_case("mid", pack9(70, 60, 60, 60, 60, 0), 40, 40);
        run_case("asym", pack9(50, 10, 20, 30, 40, 0), 100, 100);
        run_case("edge255", pack9(64, 1, 0, 0, 0, 0), 255, 255);
        run_case("edge256", pack9(64, 0, 0, 0, 0, 0), 256, 255);
        run_case("maxneg", pack9(0, 255, 255, 255, 255, 255), -1020, 0);
        run_case("maxpos", pack9(255, 0, 0, 0, 0, 255), 1020, 255);

        // backpressure with the next window already waiting
        res_ready = 1'b0;
        send_window(pack9(200, 0, 0, 0, 0, 0));
        win_pix   = pack9(70, 60, 60, 60, 60, 0);
        win_valid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("bp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_hold_data", int'($signed(res_data)), 800);
            check("bp_hold_pix", res_pix, 255);
            check("bp_win_ready", win_ready, 0);
            check("bp_coef_en", coef_en, 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_accept();
        check("bp_a_data", last_data, 800);
        check("bp_accept_gap", acc_cyc - hs_cyc, 1);
        wait_handshake();
        check("bp_b_data", last_data, 40);
        check("bp_b_pix", last_pix, 40);

        // reset in the middle of FETCH
        send_window(pack9(200, 0, 0, 0, 0, 0));
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_coef_en", coef_en, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_win_ready", win_ready, 0);
        @(posedge clk);
        #1;
        run_case("after_rst", pack9(70, 60, 60, 60, 60, 0), 40, 40);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
